// File: rtl/arb_pkg.sv
// Shared definitions for the DMEM port-B arbiter.
//   arb_state_t  : arbitration FSM states (CPU priority / forced loader slot)
//   rd_owner_t   : which requester owns the read data arriving next cycle
//   MAX_WAIT_DEFAULT : default number of consecutive loader-denied cycles
//                      before a forced loader slot
package arb_pkg;

  typedef enum logic {
    ARB_CPU   = 1'b0,
    ARB_FORCE = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_EXT  = 2'd2
  } rd_owner_t;

  localparam int MAX_WAIT_DEFAULT = 8;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating loader-starvation counter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : clear counter to 0 (has priority over inc)
//   inc        : count one more loader-denied cycle (saturates at MAX_WAIT)
//   hit        : this cycle's increment brings the count to MAX_WAIT, so the
//                next cycle must be a forced loader slot
module arb_wait_counter #(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] LAST_V = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] cnt_reg;

  // Look ahead one increment so the FSM enters the forced slot right after
  // the MAX_WAIT-th denied cycle rather than one cycle later.
  assign hit = inc && !clr && (cnt_reg >= LAST_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != MAX_V)) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// DMEM BRAM port-B arbiter between the pipeline MEM stage (priority) and an
// external loader/debug master. After MAX_WAIT consecutive cycles in which
// the loader is denied, one loader slot is forced and the CPU is stalled.
// Read data (1-cycle BRAM latency) is steered back to the issuing side.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  MEM-stage access
//   cpu_stall, cpu_rvalid              CPU hold request, CPU read data valid (data = dob)
//   ext_valid/ext_we/ext_addr/ext_wdata, ext_ready   loader valid/ready request
//   ext_rvalid, ext_rdata              loader read response (registered dob)
//   web/addrb/dib, dob                 BRAM port B
// Optional build macro DMEM_ARB_PERF_EN adds perf_cpu_stalls, perf_ext_grants
// and perf_forced wrapping event counters.
module dmem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic [DATA_W/8-1:0]   cpu_we,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  input  logic                  ext_valid,
  output logic                  ext_ready,
  input  logic [DATA_W/8-1:0]   ext_we,
  input  logic [ADDR_W-1:0]     ext_addr,
  input  logic [DATA_W-1:0]     ext_wdata,
  output logic                  ext_rvalid,
  output logic [DATA_W-1:0]     ext_rdata,
  output logic [DATA_W/8-1:0]   web,
  output logic [ADDR_W-1:0]     addrb,
  output logic [DATA_W-1:0]     dib,
  input  logic [DATA_W-1:0]     dob
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_cpu_stalls,
  output logic [31:0]           perf_ext_grants,
  output logic [31:0]           perf_forced
`endif
);

  arb_state_t state_reg;
  rd_owner_t  rd_owner_reg;
  logic       ext_rvalid_reg;
  logic [DATA_W-1:0] ext_rdata_reg;

  logic cpu_grant;
  logic ext_grant;
  logic wait_inc;
  logic wait_hit;

  // Grants are gated by rst_n so nothing reaches the BRAM while reset is held.
  // In a forced slot whose loader request vanished, the CPU is served
  // normally: cpu_stall stays low, so the MEM-stage access must go through.
  always_comb begin
    cpu_grant = 1'b0;
    ext_grant = 1'b0;
    cpu_stall = 1'b0;
    if (rst_n) begin
      if (state_reg == ARB_FORCE) begin
        if (ext_valid) begin
          ext_grant = 1'b1;
          cpu_stall = cpu_req;
        end else begin
          cpu_grant = cpu_req;
        end
      end else if (cpu_req) begin
        cpu_grant = 1'b1;
      end else begin
        ext_grant = ext_valid;
      end
    end
  end

  assign ext_ready = ext_grant;

  assign web   = cpu_grant ? cpu_we    : (ext_grant ? ext_we : '0);
  assign addrb = ext_grant ? ext_addr  : cpu_addr;
  assign dib   = ext_grant ? ext_wdata : cpu_wdata;

  // Only a loader denied by a CPU access counts; any other cycle breaks the
  // run of consecutive denials and clears the counter.
  assign wait_inc = (state_reg == ARB_CPU) && cpu_grant && ext_valid;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!wait_inc),
    .inc   (wait_inc),
    .hit   (wait_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ARB_CPU;
      rd_owner_reg   <= OWN_NONE;
      ext_rvalid_reg <= 1'b0;
      ext_rdata_reg  <= '0;
    end else begin
      case (state_reg)
        ARB_CPU:   state_reg <= wait_hit ? ARB_FORCE : ARB_CPU;
        ARB_FORCE: state_reg <= ARB_CPU;
        default:   state_reg <= ARB_CPU;
      endcase

      if (cpu_grant && (cpu_we == '0)) begin
        rd_owner_reg <= OWN_CPU;
      end else if (ext_grant && (ext_we == '0)) begin
        rd_owner_reg <= OWN_EXT;
      end else begin
        rd_owner_reg <= OWN_NONE;
      end

      // Loader data is captured from dob one cycle after the grant and
      // presented together with ext_rvalid on the following cycle.
      ext_rvalid_reg <= (rd_owner_reg == OWN_EXT);
      if (rd_owner_reg == OWN_EXT) begin
        ext_rdata_reg <= dob;
      end
    end
  end

  assign cpu_rvalid = (rd_owner_reg == OWN_CPU);
  assign ext_rvalid = ext_rvalid_reg;
  assign ext_rdata  = ext_rdata_reg;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cpu_stalls <= '0;
      perf_ext_grants <= '0;
      perf_forced     <= '0;
    end else begin
      if (cpu_stall) perf_cpu_stalls <= perf_cpu_stalls + 32'd1;
      if (ext_grant) perf_ext_grants <= perf_ext_grants + 32'd1;
      if ((state_reg == ARB_CPU) && wait_hit) perf_forced <= perf_forced + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural BRAM port-B model.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic [3:0]  cpu_we;
  logic [12:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic        ext_valid;
  logic        ext_ready;
  logic [3:0]  ext_we;
  logic [12:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_rvalid;
  logic [31:0] ext_rdata;
  logic [3:0]  web;
  logic [12:0] addrb;
  logic [31:0] dib;
  logic [31:0] dob;
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_cpu_stalls;
  logic [31:0] perf_ext_grants;
  logic [31:0] perf_forced;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(13), .DATA_W(32), .MAX_WAIT(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .ext_valid  (ext_valid),
    .ext_ready  (ext_ready),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
    .web        (web),
    .addrb      (addrb),
    .dib        (dib),
    .dob        (dob)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_cpu_stalls (perf_cpu_stalls),
    .perf_ext_grants (perf_ext_grants),
    .perf_forced     (perf_forced)
`endif
  );

  // BRAM port B: byte-enabled write, read-first, 1-cycle registered read.
  logic [31:0] mem [0:8191];
  always @(posedge clk) begin
    dob <= mem[addrb];
    for (int b = 0; b < 4; b++) begin
      if (web[b]) mem[addrb][b*8 +: 8] <= dib[b*8 +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Apply one cycle of inputs just after a rising edge; return at the falling
  // edge so combinational and registered outputs can be sampled.
  task automatic cyc(input logic cr, input logic [3:0] cw, input logic [12:0] ca,
                     input logic [31:0] cd, input logic ev, input logic [3:0] ew,
                     input logic [12:0] ea, input logic [31:0] ed);
    @(posedge clk);
    #1;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_valid = ev; ext_we = ew; ext_addr = ea; ext_wdata = ed;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 4'h0, 13'h0, 32'h0, 1'b0, 4'h0, 13'h0, 32'h0);
  endtask

  typedef struct {
    string       name;
    logic        cr;
    logic [3:0]  cw;
    logic [12:0] ca;
    logic [31:0] cd;
    logic        ev;
    logic [3:0]  ew;
    logic [12:0] ea;
    logic [31:0] ed;
    logic        e_stall;
    logic        e_ready;
    logic [3:0]  e_web;
    logic        chk_addr;
    logic [12:0] e_addrb;
    logic [31:0] e_dib;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{"idle",    1'b0, 4'h0, 13'h000, 32'h0,        1'b0, 4'h0, 13'h000, 32'h0,        1'b0, 1'b0, 4'h0, 1'b0, 13'h000, 32'h0};
    vecs[1] = '{"ext_wr",  1'b0, 4'h0, 13'h000, 32'h0,        1'b1, 4'hF, 13'h010, 32'hDEADBEEF, 1'b0, 1'b1, 4'hF, 1'b1, 13'h010, 32'hDEADBEEF};
    vecs[2] = '{"cpu_wr",  1'b1, 4'hF, 13'h004, 32'h12345678, 1'b0, 4'h0, 13'h000, 32'h0,        1'b0, 1'b0, 4'hF, 1'b1, 13'h004, 32'h12345678};
    vecs[3] = '{"cpu_wr2", 1'b1, 4'hF, 13'h008, 32'h0BADF00D, 1'b0, 4'h0, 13'h000, 32'h0,        1'b0, 1'b0, 4'hF, 1'b1, 13'h008, 32'h0BADF00D};
    vecs[4] = '{"both_rd", 1'b1, 4'h0, 13'h020, 32'h0,        1'b1, 4'hF, 13'h030, 32'h11111111, 1'b0, 1'b0, 4'h0, 1'b1, 13'h020, 32'h0};
    vecs[5] = '{"both_wr", 1'b1, 4'hC, 13'h021, 32'hCAFE0000, 1'b1, 4'hF, 13'h031, 32'h22222222, 1'b0, 1'b0, 4'hC, 1'b1, 13'h021, 32'hCAFE0000};
    vecs[6] = '{"ext_wr1", 1'b0, 4'h0, 13'h000, 32'h0,        1'b1, 4'h1, 13'h040, 32'h000000AA, 1'b0, 1'b1, 4'h1, 1'b1, 13'h040, 32'h000000AA};
    vecs[7] = '{"idle2",   1'b0, 4'h0, 13'h000, 32'h0,        1'b0, 4'h0, 13'h000, 32'h0,        1'b0, 1'b0, 4'h0, 1'b0, 13'h000, 32'h0};

    // Reset held with both requesters active.
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 4'hF; cpu_addr = 13'h3FF; cpu_wdata = 32'h0;
    ext_valid = 1'b1; ext_we = 4'hF; ext_addr = 13'h3FE; ext_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_cpu_stall",  {31'b0, cpu_stall},  32'h0);
    check("rst_ext_ready",  {31'b0, ext_ready},  32'h0);
    check("rst_cpu_rvalid", {31'b0, cpu_rvalid}, 32'h0);
    check("rst_ext_rvalid", {31'b0, ext_rvalid}, 32'h0);
    check("rst_ext_rdata",  ext_rdata,           32'h0);
    check("rst_web",        {28'b0, web},        32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    $display("txn reset_release web=%h ext_ready=%b", web, ext_ready);
    check("rel_web",       {28'b0, web},       32'hF);
    check("rel_ext_ready", {31'b0, ext_ready}, 32'h0);
    check("rel_cpu_stall", {31'b0, cpu_stall}, 32'h0);

    // Single-cycle combinational grant/mux vectors.
    for (int i = 0; i < 8; i++) begin
      cyc(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
          vecs[i].ev, vecs[i].ew, vecs[i].ea, vecs[i].ed);
      $display("txn vec %0d %s stall=%b ready=%b web=%h addrb=%h", i, vecs[i].name,
               cpu_stall, ext_ready, web, addrb);
      check({vecs[i].name, "_stall"}, {31'b0, cpu_stall}, {31'b0, vecs[i].e_stall});
      check({vecs[i].name, "_ready"}, {31'b0, ext_ready}, {31'b0, vecs[i].e_ready});
      check({vecs[i].name, "_web"},   {28'b0, web},       {28'b0, vecs[i].e_web});
      if (vecs[i].chk_addr) check({vecs[i].name, "_addrb"}, {19'b0, addrb}, {19'b0, vecs[i].e_addrb});
      if (vecs[i].e_web != 4'h0) check({vecs[i].name, "_dib"}, dib, vecs[i].e_dib);
    end

    // Loader read of 0x010: ext_rvalid two cycles after the grant.
    cyc(1'b0, 4'h0, 13'h0, 32'h0, 1'b1, 4'h0, 13'h010, 32'h0);
    $display("txn ext_read 010 ready=%b", ext_ready);
    check("extrd_ready", {31'b0, ext_ready}, 32'h1);
    check("extrd_addrb", {19'b0, addrb},     32'h010);
    idle();
    check("extrd_rv_lat1", {31'b0, ext_rvalid}, 32'h0);
    check("extrd_cpu_rv",  {31'b0, cpu_rvalid}, 32'h0);
    idle();
    $display("txn ext_read 010 rvalid=%b rdata=%h", ext_rvalid, ext_rdata);
    check("extrd_rv_lat2", {31'b0, ext_rvalid}, 32'h1);
    check("extrd_rdata",   ext_rdata,           32'hDEADBEEF);
    idle();
    check("extrd_rv_drop", {31'b0, ext_rvalid}, 32'h0);

    // CPU read 0x004 then loader read 0x008 back to back.
    cyc(1'b1, 4'h0, 13'h004, 32'h0, 1'b0, 4'h0, 13'h0, 32'h0);
    check("b2b_cpu_addrb", {19'b0, addrb}, 32'h004);
    cyc(1'b0, 4'h0, 13'h0, 32'h0, 1'b1, 4'h0, 13'h008, 32'h0);
    $display("txn b2b cpu_rvalid=%b dob=%h ext_ready=%b", cpu_rvalid, dob, ext_ready);
    check("b2b_cpu_rvalid", {31'b0, cpu_rvalid}, 32'h1);
    check("b2b_cpu_data",   dob,                 32'h12345678);
    check("b2b_ext_rv0",    {31'b0, ext_rvalid}, 32'h0);
    check("b2b_ext_ready",  {31'b0, ext_ready},  32'h1);
    idle();
    check("b2b_cpu_rv_off", {31'b0, cpu_rvalid}, 32'h0);
    check("b2b_ext_rv1",    {31'b0, ext_rvalid}, 32'h0);
    idle();
    $display("txn b2b ext_rvalid=%b ext_rdata=%h", ext_rvalid, ext_rdata);
    check("b2b_ext_rv2",   {31'b0, ext_rvalid}, 32'h1);
    check("b2b_cpu_rv2",   {31'b0, cpu_rvalid}, 32'h0);
    check("b2b_ext_rdata", ext_rdata,           32'h0BADF00D);

    // Continuous contention: forced loader slot every 9th cycle.
    for (int k = 1; k <= 27; k++) begin
      logic exp_f;
      exp_f = ((k % 9) == 0);
      cyc(1'b1, 4'h0, 13'h100, 32'h0, 1'b1, 4'hF, 13'h200, 32'h55AA55AA);
      $display("txn contend %0d stall=%b ready=%b web=%h", k, cpu_stall, ext_ready, web);
      check("cont_stall", {31'b0, cpu_stall}, {31'b0, exp_f});
      check("cont_ready", {31'b0, ext_ready}, {31'b0, exp_f});
      check("cont_web",   {28'b0, web},       exp_f ? 32'hF : 32'h0);
    end
`ifdef DMEM_ARB_PERF_EN
    idle();
    check("perf_forced",     perf_forced,     32'd3);
    check("perf_cpu_stalls", perf_cpu_stalls, 32'd3);
    check("perf_ext_grants", perf_ext_grants, 32'd7);
`endif

    // Loader request vanishes in the forced slot.
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 4'h0, 13'h100, 32'h0, 1'b1, 4'hF, 13'h200, 32'h0);
      check("drop_pre_ready", {31'b0, ext_ready}, 32'h0);
    end
    cyc(1'b1, 4'hF, 13'h300, 32'h00000077, 1'b0, 4'hF, 13'h200, 32'h0);
    $display("txn force_drop stall=%b ready=%b web=%h addrb=%h", cpu_stall, ext_ready, web, addrb);
    check("drop_stall", {31'b0, cpu_stall}, 32'h0);
    check("drop_ready", {31'b0, ext_ready}, 32'h0);
    check("drop_web",   {28'b0, web},       32'hF);
    check("drop_addrb", {19'b0, addrb},     32'h300);
    cyc(1'b1, 4'h0, 13'h100, 32'h0, 1'b1, 4'hF, 13'h200, 32'h0);
    check("drop_back_cpu_ready", {31'b0, ext_ready}, 32'h0);
    check("drop_back_cpu_stall", {31'b0, cpu_stall}, 32'h0);
    idle();

    // Reset right after a loader read grant drops the response.
    cyc(1'b0, 4'h0, 13'h0, 32'h0, 1'b1, 4'h0, 13'h010, 32'h0);
    check("rstrd_ready", {31'b0, ext_ready}, 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    cpu_req = 1'b0; ext_valid = 1'b0; ext_we = 4'h0;
    @(negedge clk);
    check("rstrd_rv_a", {31'b0, ext_rvalid}, 32'h0);
    @(negedge clk);
    check("rstrd_rv_b",   {31'b0, ext_rvalid}, 32'h0);
    check("rstrd_rdata",  ext_rdata,           32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rstrd_rv_c", {31'b0, ext_rvalid}, 32'h0);
    @(negedge clk);
    $display("txn reset_drop ext_rvalid=%b", ext_rvalid);
    check("rstrd_rv_d", {31'b0, ext_rvalid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
